// File: rtl/ahb_ram_bridge_pkg.sv
// rtl/ahb_ram_bridge_pkg.sv - shared encodings for the AHB-Lite RAM bridge
package ahb_ram_bridge_pkg;

  // Bridge FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // HSIZE encodings understood by the lane decoder
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/ahb_ram_bridge_lane_decode.sv
// rtl/ahb_ram_bridge_lane_decode.sv - HSIZE/HADDR[1:0] to byte-lane strobes and misalign flag
module ahb_lane_decode
  import ahb_ram_bridge_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] lanes_o,
  output logic       misalign_o
);

  // Lanes ignore low address bits below the transfer alignment; oversize counts as word
  always_comb begin
    lanes_o    = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: lanes_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        lanes_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      HSIZE_WORD: misalign_o = (addr_lo_i != 2'b00);
      default:    misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_ram_bridge.sv
// rtl/ahb_ram_bridge.sv - zero-wait AHB-Lite slave for byte-lane RAM; AHB_RAM_ALIGN_CHECK_EN enables ERROR on misaligned transfers
module ahb_ram_bridge
  import ahb_ram_bridge_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic                      HREADY,
  input  logic [31:0]               HWDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr_in,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr_out,
  output logic [3:0]                ram_size_decode,
  output logic [31:0]               ram_data_in,
  input  logic [31:0]               ram_data_out
);

  localparam int AW = MEM_ADDR_WIDTH;

  state_e        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [3:0]    wlanes_q, wlanes_d;
  logic          fwd_q, fwd_d;
  logic [31:0]   fwd_data_q, fwd_data_d;
  logic [3:0]    fwd_lanes_q, fwd_lanes_d;

  logic [3:0]    lanes;
  logic          misalign;
  logic          accept;
  logic          bad;
  logic          rd_addr_phase;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] haddr_word;
  logic          unused_bits;

  ahb_lane_decode u_lane_decode (
    .size_i     (HSIZE),
    .addr_lo_i  (HADDR[1:0]),
    .lanes_o    (lanes),
    .misalign_o (misalign)
  );

  // Upper address bits wrap within the RAM; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here
  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  assign haddr_word = HADDR[AW+1:2];
  // ERR1 is the only wait state, so no address phase is sampled during it
  assign accept     = HSEL & HTRANS[1] & HREADY & (state_q != ST_ERR1);

`ifdef AHB_RAM_ALIGN_CHECK_EN
  assign bad = misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign bad = 1'b0;
`endif

  assign rd_addr_phase = accept & ~HWRITE;
  assign wr_acc        = accept & HWRITE & ~bad;
  assign rd_acc        = accept & ~HWRITE & ~bad;

  // RAM read port is registered, so its address goes out in the address phase
  assign ram_addr_out = rd_addr_phase ? haddr_word : raddr_q;
  assign ram_addr_in  = waddr_q;
  assign ram_data_in  = HWDATA;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wlanes_q    <= 4'b0000;
      fwd_q       <= 1'b0;
      fwd_data_q  <= 32'h0;
      fwd_lanes_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wlanes_q    <= wlanes_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      fwd_lanes_q <= fwd_lanes_d;
    end
  end

  // Next state: ERR1 always steps to ERR2, otherwise decided by the sampled address phase
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (accept) begin
      if (bad)         state_d = ST_ERR1;
      else if (HWRITE) state_d = ST_WR;
      else             state_d = ST_RD;
    end
  end

  // Capture write address/lanes, last read address, and forwarding data for read-after-write
  always_comb begin
    waddr_d     = waddr_q;
    wlanes_d    = wlanes_q;
    raddr_d     = raddr_q;
    fwd_d       = 1'b0;
    fwd_data_d  = fwd_data_q;
    fwd_lanes_d = fwd_lanes_q;
    if (wr_acc) begin
      waddr_d  = haddr_word;
      wlanes_d = lanes;
    end
    if (rd_addr_phase) raddr_d = haddr_word;
    // The RAM reads the old word at the same edge the pending write commits
    if (rd_acc && (state_q == ST_WR) && (haddr_word == waddr_q)) begin
      fwd_d       = 1'b1;
      fwd_data_d  = HWDATA;
      fwd_lanes_d = wlanes_q;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    HREADYOUT       = (state_q != ST_ERR1);
`ifdef AHB_RAM_ALIGN_CHECK_EN
    HRESP           = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    HRESP           = 1'b0;
`endif
    ram_size_decode = (state_q == ST_WR) ? wlanes_q : 4'b0000;
    HRDATA          = 32'h0;
    if (state_q == ST_RD) begin
      for (int n = 0; n < 4; n++) begin
        HRDATA[8*n +: 8] = (fwd_q && fwd_lanes_q[n]) ? fwd_data_q[8*n +: 8]
                                                     : ram_data_out[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_ram_bridge.sv
// tb/tb_ahb_ram_bridge.sv - self-checking bench for ahb_ram_bridge with RAM and byte-level reference model
module tb_ahb_ram_bridge;

  localparam int AW    = 14;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] ram_addr_in;
  logic [AW-1:0] ram_addr_out;
  logic [3:0]    ram_size_decode;
  logic [31:0]   ram_data_in;
  logic [31:0]   ram_data_out;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rd;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } xfer_t;

  xfer_t seq[$];

  bit [31:0] mem [WORDS];
  bit [7:0]  ref_mem [4*WORDS];

  always #5 clk = ~clk;

  ahb_ram_bridge #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .HSEL            (HSEL),
    .HADDR           (HADDR),
    .HTRANS          (HTRANS),
    .HSIZE           (HSIZE),
    .HWRITE          (HWRITE),
    .HREADY          (HREADY),
    .HWDATA          (HWDATA),
    .HREADYOUT       (HREADYOUT),
    .HRESP           (HRESP),
    .HRDATA          (HRDATA),
    .ram_addr_in     (ram_addr_in),
    .ram_addr_out    (ram_addr_out),
    .ram_size_decode (ram_size_decode),
    .ram_data_in     (ram_data_in),
    .ram_data_out    (ram_data_out)
  );

  // Byte-lane block RAM with registered read (read-before-write)
  always @(posedge clk) begin
    ram_data_out <= mem[ram_addr_out];
    for (int b = 0; b < 4; b++)
      if (ram_size_decode[b]) mem[ram_addr_in][8*b +: 8] <= ram_data_in[8*b +: 8];
  end

  function automatic xfer_t mk(bit wr, bit [31:0] addr, bit [2:0] size, bit [31:0] wdata);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  function automatic int widx(bit [31:0] addr);
    return int'((addr / 4) % WORDS);
  endfunction

  // Bytes touched: transfer size clipped to a word, start rounded down to its alignment
  function automatic bit [3:0] ref_lanes(bit [31:0] addr, bit [2:0] size);
    int nbytes;
    int base;
    bit [3:0] m;
    nbytes = (size >= 2) ? 4 : (1 << size);
    base   = (int'(addr % 4) / nbytes) * nbytes;
    m      = 4'((1 << nbytes) - 1);
    return m << base;
  endfunction

  function automatic bit [31:0] ref_word(bit [31:0] addr);
    bit [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[widx(addr)*4 + b];
    return w;
  endfunction

  task automatic ref_write(bit [31:0] addr, bit [2:0] size, bit [31:0] wdata);
    bit [3:0] m;
    m = ref_lanes(addr, size);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[widx(addr)*4 + b] = wdata[8*b +: 8];
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'd0;
  endtask

  task automatic drive(xfer_t x);
    HSEL = x.sel; HTRANS = x.trans; HWRITE = x.wr; HADDR = x.addr; HSIZE = x.size;
  endtask

  // Pipelined driver: address phase of seq[c] overlaps data phase of seq[c-1]
  task automatic run_seq();
    int n;
    bit acc;
    logic [AW-1:0] ew;
    n = seq.size();
    for (int c = 0; c <= n; c++) begin
      @(posedge clk); #1;
      HREADY = 1'b1;
      if (c < n) drive(seq[c]); else drive_idle();
      HWDATA = (c > 0 && seq[c-1].wr) ? seq[c-1].wdata : $urandom;
      @(negedge clk);
      if (c > 0) begin
        acc = seq[c-1].sel && seq[c-1].trans[1];
        if (acc) begin
          tests++;
          if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            fails++;
            $display("FAIL resp: HREADYOUT=%b HRESP=%b expected 1/0", HREADYOUT, HRESP);
          end
          if (seq[c-1].wr) begin
            ew = AW'(widx(seq[c-1].addr));
            tests++;
            if (ram_size_decode !== ref_lanes(seq[c-1].addr, seq[c-1].size) || ram_addr_in !== ew) begin
              fails++;
              $display("FAIL write_strobe @%h: decode=%b addr_in=%h expected %b/%h", seq[c-1].addr,
                       ram_size_decode, ram_addr_in, ref_lanes(seq[c-1].addr, seq[c-1].size), ew);
            end
            ref_write(seq[c-1].addr, seq[c-1].size, seq[c-1].wdata);
          end else begin
            last_rd = HRDATA;
            tests++;
            if (HRDATA !== ref_word(seq[c-1].addr)) begin
              fails++;
              $display("FAIL read_data @%h: got %h expected %h", seq[c-1].addr, HRDATA, ref_word(seq[c-1].addr));
            end
          end
        end else begin
          tests++;
          if (ram_size_decode !== 4'b0000) begin
            fails++;
            $display("FAIL idle_decode: got %b expected 0000", ram_size_decode);
          end
        end
      end
    end
    seq.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; HREADY = 1'b1; HWDATA = 32'h0; drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || ram_size_decode !== 4'b0000 || HRDATA !== 32'h0
        || ram_addr_in !== '0 || ram_addr_out !== '0) begin
      fails++;
      $display("FAIL reset: rdy=%b resp=%b dec=%b rdata=%h ain=%h aout=%h expected 1/0/0000/0/0/0",
               HREADYOUT, HRESP, ram_size_decode, HRDATA, ram_addr_in, ram_addr_out);
    end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_word_rw();
    seq.push_back(mk(1, 32'h04, 3'd2, 32'hDEADBEEF));
    seq.push_back(mk(0, 32'h04, 3'd2, 32'h0));
    run_seq();
    tests++;
    if (last_rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL word_rw: got %h expected deadbeef", last_rd);
    end
  endtask

  task automatic test_byte_merge();
    seq.push_back(mk(1, 32'h04, 3'd2, 32'h11223344));
    seq.push_back(mk(1, 32'h05, 3'd0, 32'h0000AA00));
    seq.push_back(mk(0, 32'h04, 3'd2, 32'h0));
    run_seq();
    tests++;
    if (last_rd !== 32'h1122AA44) begin
      fails++; $display("FAIL byte_merge: got %h expected 1122aa44", last_rd);
    end
  endtask

  task automatic test_forwarding();
    seq.push_back(mk(1, 32'h08, 3'd2, 32'h00000000));
    run_seq();
    seq.push_back(mk(1, 32'h0A, 3'd1, 32'hBEEF0000));
    seq.push_back(mk(0, 32'h08, 3'd2, 32'h0));
    run_seq();
    tests++;
    if (last_rd !== 32'hBEEF0000) begin
      fails++; $display("FAIL forwarding: got %h expected beef0000", last_rd);
    end
  endtask

  task automatic test_no_hready();
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h20; HSIZE = 3'd2; HREADY = 1'b0;
    @(posedge clk); #1;
    drive_idle(); HREADY = 1'b1; HWDATA = 32'hFFFFFFFF;
    @(negedge clk);
    tests++;
    if (ram_size_decode !== 4'b0000 || HREADYOUT !== 1'b1) begin
      fails++; $display("FAIL no_hready: decode=%b rdy=%b expected 0000/1", ram_size_decode, HREADYOUT);
    end
    seq.push_back(mk(0, 32'h20, 3'd2, 32'h0));
    run_seq();
  endtask

  task automatic test_misaligned();
`ifdef AHB_RAM_ALIGN_CHECK_EN
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h02; HSIZE = 3'd2; HREADY = 1'b1;
    @(posedge clk); #1;
    drive_idle(); HREADY = 1'b0; HWDATA = 32'h12345678;
    @(negedge clk);
    tests++;
    if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || ram_size_decode !== 4'b0000) begin
      fails++; $display("FAIL err_cycle1: rdy=%b resp=%b dec=%b expected 0/1/0000", HREADYOUT, HRESP, ram_size_decode);
    end
    @(posedge clk); #1 HREADY = 1'b1;
    @(negedge clk);
    tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || ram_size_decode !== 4'b0000) begin
      fails++; $display("FAIL err_cycle2: rdy=%b resp=%b dec=%b expected 1/1/0000", HREADYOUT, HRESP, ram_size_decode);
    end
    seq.push_back(mk(0, 32'h00, 3'd2, 32'h0));
    run_seq();
`else
    seq.push_back(mk(1, 32'h02, 3'd2, 32'hA5A55A5A));
    seq.push_back(mk(0, 32'h00, 3'd2, 32'h0));
    run_seq();
    tests++;
    if (last_rd !== 32'hA5A55A5A) begin
      fails++; $display("FAIL misaligned_word: got %h expected a5a55a5a", last_rd);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    seq.push_back(mk(1, 32'h10, 3'd2, 32'h5A5A1234));
    run_seq();
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd2; HREADY = 1'b1;
    @(posedge clk); #1;
    drive_idle(); HWDATA = 32'hCAFEF00D;
    #1;
    tests++;
    if (ram_size_decode !== 4'hF) begin
      fails++; $display("FAIL mid_wr_decode: got %b expected 1111", ram_size_decode);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (ram_size_decode !== 4'b0000 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      fails++; $display("FAIL reset_abort: dec=%b rdy=%b resp=%b expected 0000/1/0", ram_size_decode, HREADYOUT, HRESP);
    end
    @(posedge clk); #1 rstn = 1'b1;
    seq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
    run_seq();
    tests++;
    if (last_rd !== 32'h5A5A1234) begin
      fails++; $display("FAIL reset_keeps_mem: got %h expected 5a5a1234", last_rd);
    end
  endtask

  task automatic test_back_to_back();
    xfer_t x;
    int r;
    for (int i = 0; i < 300; i++) begin
      x = mk($urandom_range(0, 1), 32'h0, 3'd0, $urandom);
      x.addr = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) x.addr = $urandom;
`ifdef AHB_RAM_ALIGN_CHECK_EN
      x.size = 3'($urandom_range(0, 2));
      x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
`else
      x.size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
`endif
      r = $urandom_range(0, 9);
      if (r == 0)      x.sel = 1'b0;
      else if (r == 1) x.trans = 2'b00;
      else if (r == 2) x.trans = 2'b01;
      else             x.trans = 2'($urandom_range(2, 3));
      seq.push_back(x);
    end
    run_seq();
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_merge();
    test_forwarding();
    test_no_hready();
    test_misaligned();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
